// File: rtl/event_rate_led_meter.sv
// rtl/event_rate_led_meter.sv - multi-channel windowed event-rate meter with LED display modes
//
// Purpose:
//   Counts single-cycle event pulses per channel over a fixed window of
//   TICK_CYC clocks, latches the per-channel rates at the end of each window,
//   tracks a held peak per channel and renders one of four views on the LEDs.
//   Event inputs are assumed to be in the clk domain already.
//
// Ports:
//   clk         single clock for all logic
//   rst         synchronous, active-high reset
//   event_in    per-channel event pulses, one count per high cycle
//   mode        0=raw, 1=log bar, 2=activity, 3=peak-hold
//   ch_sel      channel shown in modes 0/1/3 (out-of-range selects blank the LEDs)
//   clear       synchronous soft clear, same effect as rst
//   led         LED drive, high = on (registered)
//   rate_out    latched rates, channel i in bits [i*CNT_W +: CNT_W]
//   rate_valid  one-cycle pulse when rate_out updates
//   overflow    channel saturated during the last completed window

module event_rate_led_meter #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int LED_W        = 4,
  parameter int CLK_HZ       = 25_000_000,
  parameter int WINDOW_MS    = 100,
  parameter int HOLD_WINDOWS = 8,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       event_in,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        ch_sel,
  input  logic                    clear,
  output logic [LED_W-1:0]        led,
  output logic [NUM_CH*CNT_W-1:0] rate_out,
  output logic                    rate_valid,
  output logic [NUM_CH-1:0]       overflow
);

  localparam int TICK_CYC = (CLK_HZ / 1000) * WINDOW_MS;
  localparam int WIN_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int HOLD_W   = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
  localparam int MW       = (CNT_W > LED_W) ? CNT_W : LED_W;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(TICK_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_WINDOWS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SEL_W:0]    NUM_CH_L  = (SEL_W + 1)'(NUM_CH);
  localparam logic [MW-1:0]     LED_MAX_W = MW'({LED_W{1'b1}});

  // Window timing
  logic [WIN_W-1:0] win_cnt;
  logic             tick;

  assign tick = (win_cnt == WIN_LAST);

  // Per-channel measurement state
  logic [CNT_W-1:0]  acc      [NUM_CH];
  logic [CNT_W-1:0]  rate     [NUM_CH];
  logic [CNT_W-1:0]  peak     [NUM_CH];
  logic [HOLD_W-1:0] hold     [NUM_CH];
  logic [NUM_CH-1:0] ovf_pend;

  // Display path
  logic              sel_valid;
  logic [SEL_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  sel_rate;
  logic [CNT_W-1:0]  sel_peak;
  logic [LED_W-1:0]  act_bits;
  logic [LED_W-1:0]  led_next;

  // Saturating raw map: values that do not fit on the LEDs show all ones.
  function automatic logic [LED_W-1:0] raw_map(input logic [CNT_W-1:0] v);
    logic [MW-1:0] vw;
    vw = MW'(v);
    if (vw > LED_MAX_W) begin
      return {LED_W{1'b1}};
    end
    return vw[LED_W-1:0];
  endfunction

  // Log bar: LED j is lit when v >= 2^j, which lights exactly the lowest
  // min(LED_W, bit_length(v)) LEDs, i.e. floor(log2(v))+1 capped at LED_W.
  function automatic logic [LED_W-1:0] log_map(input logic [CNT_W-1:0] v);
    logic [MW-1:0]    vw;
    logic [LED_W-1:0] bar;
    vw  = MW'(v);
    bar = '0;
    for (int j = 0; j < LED_W; j++) begin
      bar[j] = ((vw >> j) != '0);
    end
    return bar;
  endfunction

  // Measurement: window counter, accumulators, rate latch, overflow, peaks.
  // clear shares the reset path so it wins over events and the tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_cnt    <= '0;
      rate_valid <= 1'b0;
      ovf_pend   <= '0;
      overflow   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        rate[i] <= '0;
        peak[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      win_cnt    <= tick ? '0 : win_cnt + WIN_W'(1);
      rate_valid <= tick;
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick) begin
          rate[i]     <= acc[i];
          overflow[i] <= ovf_pend[i] | (event_in[i] & (acc[i] == CNT_MAX));
          // A tick-cycle event opens the next window's count.
          acc[i]      <= event_in[i] ? CNT_W'(1) : '0;
          ovf_pend[i] <= 1'b0;
          // Peak tracks the rate being latched this cycle (acc[i]).
          if (acc[i] >= peak[i]) begin
            peak[i] <= acc[i];
            hold[i] <= HOLD_LOAD;
          end else if (hold[i] == '0) begin
            peak[i] <= acc[i];
          end else begin
            hold[i] <= hold[i] - HOLD_W'(1);
          end
        end else if (event_in[i]) begin
          if (acc[i] == CNT_MAX) begin
            ovf_pend[i] <= 1'b1;
          end else begin
            acc[i] <= acc[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_rate_out
      assign rate_out[g*CNT_W +: CNT_W] = rate[g];
    end
    for (g = 0; g < LED_W; g++) begin : g_act
      if (g < NUM_CH) begin : g_used
        assign act_bits[g] = (rate[g] != '0);
      end else begin : g_unused
        assign act_bits[g] = 1'b0;
      end
    end
  endgenerate

  // Channel select; an out-of-range select is steered to channel 0 for the
  // array read and blanked below.
  always_comb begin
    sel_valid = ({1'b0, ch_sel} < NUM_CH_L);
    sel_idx   = sel_valid ? ch_sel : '0;
    sel_rate  = rate[sel_idx];
    sel_peak  = peak[sel_idx];
  end

  always_comb begin
    led_next = '0;
    case (mode)
      2'd0: begin
        if (sel_valid) begin
          led_next = raw_map(sel_rate);
        end
      end
      2'd1: begin
        if (sel_valid) begin
          led_next = log_map(sel_rate);
        end
      end
      2'd2: begin
        led_next = act_bits;
      end
      default: begin
        if (sel_valid) begin
          led_next = raw_map(sel_peak);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_event_rate_led_meter.sv
// tb/tb_event_rate_led_meter.sv - self-checking bench for event_rate_led_meter
module tb_event_rate_led_meter;

  localparam int TICK  = 10;
  localparam int HOLDW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  ev = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  ch_sel = '0;

  logic [3:0]  led_a;
  logic [15:0] rate_a;
  logic        rv_a;
  logic [3:0]  ovf_a;
  logic [3:0]  led_b;
  logic [8:0]  rate_b;
  logic        rv_b;
  logic [2:0]  ovf_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  event_rate_led_meter #(
    .NUM_CH(4), .CNT_W(4), .LED_W(4), .CLK_HZ(1000), .WINDOW_MS(10), .HOLD_WINDOWS(HOLDW)
  ) dut_a (
    .clk(clk), .rst(rst), .event_in(ev), .mode(mode), .ch_sel(ch_sel), .clear(clear),
    .led(led_a), .rate_out(rate_a), .rate_valid(rv_a), .overflow(ovf_a)
  );

  event_rate_led_meter #(
    .NUM_CH(3), .CNT_W(3), .LED_W(4), .CLK_HZ(1000), .WINDOW_MS(10), .HOLD_WINDOWS(HOLDW)
  ) dut_b (
    .clk(clk), .rst(rst), .event_in(ev[2:0]), .mode(mode), .ch_sel(ch_sel), .clear(clear),
    .led(led_b), .rate_out(rate_b), .rate_valid(rv_b), .overflow(ovf_b)
  );

  // Reference model: unbounded event counts per window, clipped on latch.
  // m_pos is the window position of the next clock edge.
  int m_pos  [2];
  int m_cnt  [2][4];
  int m_rate [2][4];
  int m_ovf  [2][4];
  int m_peak [2][4];
  int m_hold [2][4];
  int m_rv   [2];
  int m_led  [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_led(input int k, input int nch);
    int sel = int'(ch_sel);
    int v;
    int kk;
    int r = 0;
    if (mode == 2'd2) begin
      for (int j = 0; j < 4 && j < nch; j++) begin
        if (m_rate[k][j] != 0) r = r | (1 << j);
      end
    end else if (sel < nch) begin
      v = (mode == 2'd3) ? m_peak[k][sel] : m_rate[k][sel];
      if (mode == 2'd1) begin
        kk = (v == 0) ? 0 : $clog2(v + 1);
        if (kk > 4) kk = 4;
        r = (1 << kk) - 1;
      end else begin
        r = (v > 15) ? 15 : v;
      end
    end
    return r;
  endfunction

  task automatic model_step(input int k, input int nch, input int maxv);
    int nl;
    int e;
    if (rst || clear) begin
      m_pos[k] = 0;
      m_rv[k]  = 0;
      m_led[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0; m_rate[k][i] = 0; m_ovf[k][i] = 0;
        m_peak[k][i] = 0; m_hold[k][i] = 0;
      end
      return;
    end
    nl = model_led(k, nch);
    if (m_pos[k] == TICK - 1) begin
      for (int i = 0; i < nch; i++) begin
        e = int'(ev[i]);
        m_ovf[k][i]  = ((m_cnt[k][i] + e) > maxv) ? 1 : 0;
        m_rate[k][i] = (m_cnt[k][i] > maxv) ? maxv : m_cnt[k][i];
        m_cnt[k][i]  = e;
        if (m_rate[k][i] >= m_peak[k][i]) begin
          m_peak[k][i] = m_rate[k][i];
          m_hold[k][i] = HOLDW - 1;
        end else if (m_hold[k][i] == 0) begin
          m_peak[k][i] = m_rate[k][i];
        end else begin
          m_hold[k][i] = m_hold[k][i] - 1;
        end
      end
      m_rv[k]  = 1;
      m_pos[k] = 0;
    end else begin
      for (int i = 0; i < nch; i++) m_cnt[k][i] = m_cnt[k][i] + int'(ev[i]);
      m_rv[k]  = 0;
      m_pos[k] = m_pos[k] + 1;
    end
    m_led[k] = nl;
  endtask

  function automatic int pack_val(input int k, input int nch, input int w, input bit ovf);
    int r = 0;
    for (int i = 0; i < nch; i++) r = r | ((ovf ? m_ovf[k][i] : m_rate[k][i]) << (i * w));
    return r;
  endfunction

  always @(posedge clk) begin
    model_step(0, 4, 15);
    model_step(1, 3, 7);
  end

  always @(negedge clk) begin
    chk("rate_a", int'(rate_a), pack_val(0, 4, 4, 1'b0));
    chk("ovf_a",  int'(ovf_a),  pack_val(0, 4, 1, 1'b1));
    chk("rv_a",   int'(rv_a),   m_rv[0]);
    chk("led_a",  int'(led_a),  m_led[0]);
    chk("rate_b", int'(rate_b), pack_val(1, 3, 3, 1'b0));
    chk("ovf_b",  int'(ovf_b),  pack_val(1, 3, 1, 1'b1));
    chk("rv_b",   int'(rv_b),   m_rv[1]);
    chk("led_b",  int'(led_b),  m_led[1]);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Steady pattern: ch0 3 events, ch1 always high, ch3 5 events per window.
  function automatic logic [3:0] pat(input int p);
    logic [3:0] r;
    r[0] = (p < 3);
    r[1] = 1'b1;
    r[2] = 1'b0;
    r[3] = (p < 5);
    return r;
  endfunction

  task automatic pstep();
    ev = pat(m_pos[0]);
    step();
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] led_a;
    logic [3:0] led_b;
  } vec_t;

  vec_t tbl[11];
  int   pk_rate[5];
  int   pk_led[4];

  initial begin
    // Steady rates: A = {3,10,0,5}, B = {3,7,0}; peaks equal rates.
    tbl[0]  = '{2'd0, 2'd0, 4'b0011, 4'b0011};
    tbl[1]  = '{2'd0, 2'd1, 4'b1010, 4'b0111};
    tbl[2]  = '{2'd0, 2'd2, 4'b0000, 4'b0000};
    tbl[3]  = '{2'd0, 2'd3, 4'b0101, 4'b0000};
    tbl[4]  = '{2'd1, 2'd0, 4'b0011, 4'b0011};
    tbl[5]  = '{2'd1, 2'd1, 4'b1111, 4'b0111};
    tbl[6]  = '{2'd1, 2'd3, 4'b0111, 4'b0000};
    tbl[7]  = '{2'd2, 2'd0, 4'b1011, 4'b0011};
    tbl[8]  = '{2'd2, 2'd2, 4'b1011, 4'b0011};
    tbl[9]  = '{2'd3, 2'd1, 4'b1010, 4'b0111};
    tbl[10] = '{2'd3, 2'd3, 4'b0101, 4'b0000};
    pk_rate = '{6, 2, 1, 1, 0};
    pk_led  = '{6, 6, 1, 1};

    // 1: reset state, 3 pulses on ch0, raw mode
    step();
    chk("rst_rate", int'(rate_a), 0);
    chk("rst_led", int'(led_a), 0);
    chk("rst_rv", int'(rv_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    step();
    rst = 1'b0; mode = 2'd0; ch_sel = 2'd0; ev = 4'b0001;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (s == 3) ev = 4'b0000;
      if (s == 9) chk("s1_rv_early", int'(rv_a), 0);
      if (s == 10) begin
        chk("s1_rv", int'(rv_a), 1);
        chk("s1_rate0", int'(rate_a[3:0]), 3);
        chk("s1_ovf", int'(ovf_a), 0);
      end
      if (s == 11) chk("s1_led", int'(led_a), 4'b0011);
      if (s == 20) chk("s1_rv_next", int'(rv_a), 1);
    end

    // 2: ch1 held high through ticks, log bar
    do_clear();
    ev = 4'b0010; mode = 2'd1; ch_sel = 2'd1;
    for (int s = 1; s <= 41; s++) begin
      step();
      if (s == 10) chk("s2_rate_w1", int'(rate_a[7:4]), 9);
      if (s == 11) chk("s2_led_w1", int'(led_a), 4'b1111);
      if (s == 20) begin
        chk("s2_rate_w2", int'(rate_a[7:4]), 10);
        ev = 4'b0000;
      end
      if (s == 21) chk("s2_led_w2", int'(led_a), 4'b1111);
      if (s == 30) begin
        chk("s2_rate_carry", int'(rate_a[7:4]), 1);
        ev = 4'b0010;
      end
      if (s == 31) chk("s2_led_carry", int'(led_a), 4'b0001);
      if (s == 32) ev = 4'b0000;
      if (s == 40) chk("s2_rate_two", int'(rate_a[7:4]), 2);
      if (s == 41) chk("s2_led_two", int'(led_a), 4'b0011);
    end

    // 3: saturation and overflow on the narrow-counter instance
    do_clear();
    ev = 4'b0100; mode = 2'd0; ch_sel = 2'd2;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (s == 10) begin
        chk("s3_rate_b", int'(rate_b[8:6]), 7);
        chk("s3_ovf_b", int'(ovf_b[2]), 1);
        chk("s3_rate_a", int'(rate_a[11:8]), 9);
      end
      if (s == 11) chk("s3_led_b", int'(led_b), 4'b0111);
      if (s == 20) begin
        chk("s3_rate_b2", int'(rate_b[8:6]), 7);
        chk("s3_ovf_b2", int'(ovf_b[2]), 1);
        chk("s3_ovf_a", int'(ovf_a), 0);
        ev = 4'b0000;
      end
      if (s == 30) chk("s3_ovf_clr", int'(ovf_b[2]), 0);
      if (s == 40) chk("s3_rate_quiet", int'(rate_b[8:6]), 0);
    end

    // 4: activity mode ignores ch_sel
    do_clear();
    mode = 2'd2; ev = 4'b1001;
    step();
    ev = 4'b0000;
    for (int s = 2; s <= 11; s++) step();
    chk("s4_led_a", int'(led_a), 4'b1001);
    chk("s4_led_b", int'(led_b), 4'b0001);
    for (int s = 1; s <= 3; s++) begin
      ch_sel = 2'(s);
      step();
      chk("s4_led_sel", int'(led_a), 4'b1001);
    end

    // 5: peak hold on ch0 with rates 6,2,1,1
    do_clear();
    mode = 2'd3; ch_sel = 2'd0;
    for (int w = 0; w < 5; w++) begin
      for (int s = 0; s < TICK; s++) begin
        ev = (m_pos[0] < pk_rate[w]) ? 4'b0001 : 4'b0000;
        step();
        if (w > 0 && s == 0) chk("s5_peak_led", int'(led_a), pk_led[w-1]);
        if (w < 4 && s == TICK - 1) chk("s5_rate", int'(rate_a[3:0]), pk_rate[w]);
      end
    end

    // 6a: clear mid-window discards the partial window
    do_clear();
    mode = 2'd0; ch_sel = 2'd0;
    for (int s = 0; s < 15; s++) begin
      ev = (m_pos[0] < 4) ? 4'b0001 : 4'b0000;
      step();
    end
    chk("s6_rate_pre", int'(rate_a[3:0]), 4);
    ev = 4'b0001;
    do_clear();
    ev = 4'b0000;
    chk("s6_rate_clr", int'(rate_a), 0);
    chk("s6_led_clr", int'(led_a), 0);
    for (int s = 1; s <= 10; s++) begin
      step();
      chk("s6_rv_gap", int'(rv_a), (s == 10) ? 1 : 0);
    end
    chk("s6_rate_after", int'(rate_a), 0);

    // 6b: clear coincident with the tick
    do_clear();
    ev = 4'b0001;
    for (int s = 0; s < 9; s++) step();
    do_clear();
    ev = 4'b0000;
    chk("s6_tick_rv", int'(rv_a), 0);
    chk("s6_tick_rate", int'(rate_a), 0);
    for (int s = 1; s <= 10; s++) begin
      step();
      chk("s6_tick_gap", int'(rv_a), (s == 10) ? 1 : 0);
    end

    // Table-driven display checks on steady rates
    do_clear();
    for (int s = 0; s < 2 * TICK; s++) pstep();
    for (int t = 0; t < 11; t++) begin
      mode   = tbl[t].mode;
      ch_sel = tbl[t].sel;
      pstep();
      chk("tbl_led_a", int'(led_a), int'(tbl[t].led_a));
      chk("tbl_led_b", int'(led_b), int'(tbl[t].led_b));
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      ev = 4'($urandom);
      if ($urandom_range(0, 3) == 0) ev = ev | 4'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) ch_sel = 2'($urandom);
      clear = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end
    clear = 1'b0;
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
